instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter IM_WORDS, default 32: number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: number of entries in the fetch buffer; the only supported value is 2.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port START, input, 1 bit: run request, sampled on the rising edge of CLK.
REQ-006 SHALL have port im_addr, output, 5 bits: instruction memory word address, equal to pc[6:2].
REQ-007 SHALL have port im_data, input, 32 bits: combinational read data of the instruction memory at im_addr, valid in the same cycle.
REQ-008 SHALL have port if_valid, output, 1 bit: the buffer head holds a valid instruction.
REQ-009 SHALL have port if_instr, output, 32 bits: the instruction at the buffer head.
REQ-010 SHALL have port if_pc, output, 32 bits: the byte address of if_instr.
REQ-011 SHALL have port id_ready, input, 1 bit: the decode/execute stage accepts the head entry.
REQ-012 SHALL have port redirect_valid, input, 1 bit: a PC change request.
REQ-013 SHALL have port redirect_pc, input, 32 bits: the new byte address for a redirect.
REQ-014 SHALL have port halted, output, 1 bit: the end of the program has been reached and the buffer is empty.

Function
REQ-015 SHALL implement states IDLE, RUN and HALT with the following transitions.
- IDLE->RUN: START=1 at a rising edge.
- RUN->HALT: on an end condition (REQ-018, REQ-019).
- HALT->RUN: only on a redirect.
REQ-016 SHALL perform a fetch in every RUN cycle in which the buffer is not full, or is full and a pop occurs in the same cycle.
- The entry {pc, im_data} is pushed at the end of that cycle.
- pc is incremented by 4 at the end of that cycle.
REQ-017 SHALL pop the head entry at a rising edge when if_valid=1 and id_ready=1; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-018 SHALL treat im_data==32'h0 in a fetch cycle as end of program: no push, pc unchanged, state->HALT.
REQ-019 SHALL enter HALT when pc>=IM_WORDS*4 in RUN, with no fetch, no push and no PC wrap-around.
REQ-020 SHALL drive if_instr and if_pc directly from buffer head registers, with no combinational path from im_data.
REQ-021 SHALL hold if_instr and if_pc stable while if_valid=1 and id_ready=0.
REQ-022 SHALL deliver entries in fetch order with no loss or duplication.
REQ-023 SHALL apply a redirect at the edge where redirect_valid=1, taking priority over push and pop in that cycle.
- The buffer is flushed.
- pc is loaded with {redirect_pc[31:2],2'b00}; bits [1:0] are ignored.
- State->RUN from any state except IDLE; redirect SHALL be ignored in IDLE.
REQ-024 SHALL assert halted only when state=HALT and the buffer is empty.
REQ-025 SHALL ignore START in RUN and HALT.
REQ-026 SHALL have latency: START sampled at edge N gives state RUN after N, the first push at N+1, and if_valid=1 after N+1.
REQ-027 SHALL, in steady state with id_ready=1, deliver one instruction per cycle.

Reset
REQ-028 SHALL, while RST=1 and independent of CLK, force pc=0, buffer empty, state IDLE, if_valid=0, if_instr=0, if_pc=0 and halted=0.
REQ-029 SHALL, after RST is asserted mid-operation, discard all buffered entries, and SHALL require START again to resume.

Verification
REQ-030 SHALL cover: IM[0..2]=nonzero, IM[3]=0, START=1, id_ready=1 -> if_pc 0x0, 0x4, 0x8 on consecutive cycles, then halted=1 and if_valid=0.
REQ-031 SHALL cover: id_ready=0 from start -> buffer holds 2 entries, pc=0x8, if_instr=IM[0] held stable; then id_ready=1 -> IM[0], IM[1], IM[2] in order.
REQ-032 SHALL cover: redirect_valid=1 with redirect_pc=0x11 while the buffer is full -> if_valid=0 in the next cycle, then if_instr=IM[4] with if_pc=0x10.
REQ-033 SHALL cover: all 32 words nonzero -> last delivery if_pc=0x7C, then halted=1, and no fetch at address 0 after it.
REQ-034 SHALL cover: RST pulsed asynchronously mid-run -> outputs read 0 before the next edge, state IDLE, no fetch until START.
REQ-035 SHALL cover: redirect while halted to 0x0 -> halted=0, and IM[0] is delivered again.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: runs a PC through a combinational instruction memory
// and feeds a two-entry fetch buffer toward decode.
module instr_fetch_unit #(
    parameter int IM_WORDS  = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic [4:0]  im_addr,
    input  logic [31:0] im_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [1:0]  DEPTH    = 2'(BUF_DEPTH);
    localparam logic [31:0] PC_LIMIT = 32'(IM_WORDS * 4);

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] head_instr, head_pc, tail_instr, tail_pc;
    logic [1:0]  count;
    logic        pop, full, in_range, push, redirect;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign im_addr  = pc[6:2];
    assign if_valid = (count != 2'd0);
    assign if_instr = head_instr;
    assign if_pc    = head_pc;
    assign halted   = (state == HALT) && (count == 2'd0);

    assign pop      = if_valid && id_ready;
    assign full     = (count == DEPTH);
    assign in_range = (pc < PC_LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        redirect  = 1'b0;
        case (state)
            IDLE: begin
                if (START) state_nxt = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    redirect = 1'b1;
                end else if (!in_range) begin
                    state_nxt = HALT;
                end else if (!full || pop) begin
                    // A zero word marks the end of the program and is never buffered.
                    if (im_data == 32'h0) state_nxt = HALT;
                    else                  push      = 1'b1;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    redirect  = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc         <= 32'h0;
            count      <= 2'd0;
            head_instr <= 32'h0;
            head_pc    <= 32'h0;
            tail_instr <= 32'h0;
            tail_pc    <= 32'h0;
        end else if (redirect) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= 2'd0;
        end else begin
            if (push) pc <= pc + 32'd4;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= im_data;
                        head_pc    <= pc;
                    end else begin
                        tail_instr <= im_data;
                        tail_pc    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (count == 2'd2) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= im_data;
                        tail_pc    <= pc;
                    end else begin
                        head_instr <= im_data;
                        head_pc    <= pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [4:0]  im_addr;
    logic [31:0] im_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halted;

    logic [31:0] im [0:31];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign im_data = im[im_addr];

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.IM_WORDS(32), .BUF_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .im_addr(im_addr), .im_data(im_data),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse placed entirely between two clock edges.
    task automatic pulse_reset();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        step();
    endtask

    task automatic fill_short();
        for (int i = 0; i < 32; i++) im[i] = 32'hA000_0000 + 32'(i) + 32'h1;
        im[3] = 32'h0;
    endtask

    task automatic fill_full();
        for (int i = 0; i < 32; i++) im[i] = 32'hB000_0000 + 32'(i) + 32'h1;
    endtask

    initial begin
        fill_short();
        #3;
        check_val("rst_valid",  {31'h0, if_valid}, 32'h0);
        check_val("rst_halted", {31'h0, halted},   32'h0);
        check_val("rst_pc",     if_pc,             32'h0);
        check_val("rst_instr",  if_instr,          32'h0);
        check_val("rst_addr",   {27'h0, im_addr},  32'h0);
        RST = 1'b0;
        step();

        // Redirect is ignored in IDLE
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check_val("idle_redir_addr",  {27'h0, im_addr},  32'h0);
        check_val("idle_redir_valid", {31'h0, if_valid}, 32'h0);

        // Short program, decode always ready
        START = 1'b1; id_ready = 1'b1;
        step();
        START = 1'b0;
        check_val("lat_valid0", {31'h0, if_valid}, 32'h0);
        step();
        check_val("seq_pc0",    if_pc,    32'h0);
        check_val("seq_instr0", if_instr, 32'hA000_0001);
        step();
        check_val("seq_pc1",    if_pc,    32'h4);
        step();
        check_val("seq_pc2",    if_pc,    32'h8);
        check_val("seq_instr2", if_instr, 32'hA000_0003);
        step();
        check_val("seq_halted", {31'h0, halted},   32'h1);
        check_val("seq_valid",  {31'h0, if_valid}, 32'h0);
        check_val("seq_addr",   {27'h0, im_addr},  32'h3);

        // Backpressure from the start
        pulse_reset();
        id_ready = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        step();
        check_val("bp_instr",  if_instr,          32'hA000_0001);
        check_val("bp_pc",     if_pc,             32'h0);
        check_val("bp_addr",   {27'h0, im_addr},  32'h2);
        START = 1'b1;
        step();
        START = 1'b0;
        check_val("bp_hold",   if_instr,          32'hA000_0001);
        check_val("bp_addr2",  {27'h0, im_addr},  32'h2);
        id_ready = 1'b1;
        step();
        check_val("bp_instr1", if_instr,          32'hA000_0002);
        check_val("bp_pc1",    if_pc,             32'h4);
        step();
        check_val("bp_instr2", if_instr,          32'hA000_0003);
        check_val("bp_halt_n", {31'h0, halted},   32'h0);
        step();
        check_val("bp_halted", {31'h0, halted},   32'h1);

        // Redirect while halted back to address 0
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        check_val("hr_halted", {31'h0, halted},   32'h0);
        check_val("hr_valid",  {31'h0, if_valid}, 32'h0);
        step();
        check_val("hr_instr",  if_instr,          32'hA000_0001);
        check_val("hr_pc",     if_pc,             32'h0);

        // Redirect with a full buffer to a misaligned address
        fill_full();
        pulse_reset();
        id_ready = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h11;
        step();
        redirect_valid = 1'b0;
        check_val("rd_valid", {31'h0, if_valid}, 32'h0);
        check_val("rd_addr",  {27'h0, im_addr},  32'h4);
        step();
        check_val("rd_instr", if_instr,          32'hB000_0005);
        check_val("rd_pc",    if_pc,             32'h10);
        id_ready = 1'b1;
        step();
        check_val("rd_pc_nx", if_pc,             32'h14);

        // Whole memory nonzero: run off the end without wrapping
        pulse_reset();
        id_ready = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step();
            check_val($sformatf("full_pc%0d", k), if_pc, 32'(k * 4));
        end
        check_val("full_last", if_instr, 32'hB000_0020);
        step();
        check_val("full_halted", {31'h0, halted},   32'h1);
        check_val("full_valid",  {31'h0, if_valid}, 32'h0);
        step();
        step();
        check_val("full_nowrap", {31'h0, if_valid}, 32'h0);
        check_val("full_stay",   {31'h0, halted},   32'h1);

        // Asynchronous reset mid-run
        pulse_reset();
        id_ready = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        RST = 1'b1;
        #1;
        check_val("ar_valid",  {31'h0, if_valid}, 32'h0);
        check_val("ar_instr",  if_instr,          32'h0);
        check_val("ar_pc",     if_pc,             32'h0);
        check_val("ar_addr",   {27'h0, im_addr},  32'h0);
        check_val("ar_halted", {31'h0, halted},   32'h0);
        #1;
        RST = 1'b0;
        id_ready = 1'b1;
        step();
        step();
        check_val("ar_nofetch", {31'h0, if_valid}, 32'h0);
        check_val("ar_addr2",   {27'h0, im_addr},  32'h0);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        check_val("ar_restart", if_instr, 32'hB000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
